// File: rtl/bcd_operand_splitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bcd_operand_splitter
// Description : Sequential double-dabble converter turning two binary operands
//               into tens/ones BCD digits for the display select mux.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_operand_splitter #(
    parameter int         WIDTH = 7,
    parameter logic [3:0] BLANK = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic [3:0]       num1ones,
    output logic [3:0]       num1tens,
    output logic [3:0]       num2ones,
    output logic [3:0]       num2tens,
    output logic             ovf1,
    output logic             ovf2
);

    localparam int             c_CW  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(99);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_bin1;
    logic [WIDTH-1:0]  r_bin2;
    logic [7:0]        r_bcd1;
    logic [7:0]        r_bcd2;
    logic [c_CW-1:0]   r_count;
    logic              r_ovf1;
    logic              r_ovf2;
    logic [7:0]        w_adj1;
    logic [7:0]        w_adj2;

    // Nibble-wise add-3 on the pre-shift accumulator; no carry between nibbles.
    function automatic logic [7:0] add3(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = (v[3:0] >= 4'd5) ? v[3:0] + 4'd3 : v[3:0];
        hi = (v[7:4] >= 4'd5) ? v[7:4] + 4'd3 : v[7:4];
        return {hi, lo};
    endfunction

    assign w_adj1 = add3(r_bcd1);
    assign w_adj2 = add3(r_bcd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_bin1   <= '0;
            r_bin2   <= '0;
            r_bcd1   <= '0;
            r_bcd2   <= '0;
            r_count  <= '0;
            r_ovf1   <= 1'b0;
            r_ovf2   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            num1ones <= 4'd0;
            num1tens <= 4'd0;
            num2ones <= 4'd0;
            num2tens <= 4'd0;
            ovf1     <= 1'b0;
            ovf2     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin1  <= num1;
                        r_bin2  <= num2;
                        r_bcd1  <= '0;
                        r_bcd2  <= '0;
                        r_count <= '0;
                        r_ovf1  <= (num1 > c_MAX);
                        r_ovf2  <= (num2 > c_MAX);
                        busy    <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bcd1  <= {w_adj1[6:0], r_bin1[WIDTH-1]};
                    r_bcd2  <= {w_adj2[6:0], r_bin2[WIDTH-1]};
                    r_bin1  <= r_bin1 << 1;
                    r_bin2  <= r_bin2 << 1;
                    r_count <= r_count + c_CW'(1);
                    if (r_count == c_CW'(WIDTH - 1)) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    num1tens <= r_ovf1 ? BLANK : r_bcd1[7:4];
                    num1ones <= r_ovf1 ? BLANK : r_bcd1[3:0];
                    num2tens <= r_ovf2 ? BLANK : r_bcd2[7:4];
                    num2ones <= r_ovf2 ? BLANK : r_bcd2[3:0];
                    ovf1     <= r_ovf1;
                    ovf2     <= r_ovf2;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
